sw_debounce_sync: RTL and testbench

Input conditioner for the slide-switch bank; it is the stage directly upstream of the load-store unit's `i_io_sw` port. Each raw, asynchronous switch line passes through a two-flop synchronizer and a per-bit stability counter. The cleaned value is presented zero-extended to 32 bits, so a load from the switch region (0x1001_0xxx) always returns a metastability-free, bounce-free word. A one-cycle change pulse is also provided for optional interrupt or event logic.

---
 rtl/sw_debounce_sync.sv | 83 ++++++++
 tb/tb_sw_debounce_sync.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchronizer plus per-bit stability counter for
// the slide-switch bank. Presents the accepted levels zero-extended to 32 bits
// and a registered one-cycle pulse whenever any accepted bit flips.
module sw_debounce_sync #(
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [SW_WIDTH-1:0] i_sw_raw,
  output logic [31:0]         o_io_sw,
  output logic                o_sw_changed
);

  localparam int            LP_CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LP_CW-1:0] LP_TC = LP_CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [SW_WIDTH-1:0] r_stable;
  logic [LP_CW-1:0]    r_cnt [SW_WIDTH];
  logic                r_changed;

  logic [SW_WIDTH-1:0] w_mismatch;
  logic [SW_WIDTH-1:0] w_flip;

  // Two-flop synchronizer; the only place the raw pins are sampled.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted on the edge its mismatch streak reaches the terminal count.
  always_comb begin
    w_mismatch = r_sync2 ^ r_stable;
    w_flip     = '0;
    for (int b = 0; b < SW_WIDTH; b++) begin
      w_flip[b] = w_mismatch[b] && (r_cnt[b] == LP_TC);
    end
  end

  // Per-bit streak counters: cleared on agreement or acceptance, else advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int b = 0; b < SW_WIDTH; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < SW_WIDTH; b++) begin
        if (!w_mismatch[b] || w_flip[b]) begin
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Accepted levels and the registered change pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_stable  <= r_stable ^ w_flip;
      r_changed <= |w_flip;
    end
  end

  // Zero-extend straight from the flops; written this way so SW_WIDTH = 32 works.
  always_comb begin
    o_io_sw                 = '0;
    o_io_sw[SW_WIDTH-1:0]   = r_stable;
  end

  assign o_sw_changed = r_changed;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: directed and randomized stimulus checked against a
// history-window reference model of the debounce rules.
module tb_sw_debounce_sync;

  localparam int W = 18;
  localparam int D = 4;
  localparam int HMAX = 8192;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  i_sw_raw;
  logic [31:0]   o_io_sw;
  logic          o_sw_changed;

  int n_vec;
  int n_miss;

  // Model: raw value captured at each post-reset edge, accepted levels, pulse.
  logic [W-1:0]  hist [HMAX];
  int            n_edge;
  logic [W-1:0]  m_stable;
  logic          m_chg;

  sw_debounce_sync #(.SW_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_sw_raw     (i_sw_raw),
    .o_io_sw      (o_io_sw),
    .o_sw_changed (o_sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [W-1:0] h(input int idx);
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  // A bit is accepted at edge n when the last D synchronized samples
  // (captured at edges n-2-D+1 .. n-2) all disagree with the accepted level.
  task automatic model_edge(input logic [W-1:0] raw);
    logic [W-1:0] flip;
    logic [W-1:0] s;
    logic         all_diff;
    if (n_edge < HMAX) hist[n_edge] = raw;
    flip = '0;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        s = h(n_edge - 2 - j);
        if (s[b] == m_stable[b]) all_diff = 1'b0;
      end
      flip[b] = all_diff;
    end
    m_stable = m_stable ^ flip;
    m_chg    = (flip != '0);
    n_edge++;
  endtask

  // Positioned just after a posedge: check at negedge, drive, take next edge.
  task automatic step(input logic [W-1:0] raw);
    @(negedge clk);
    chk("io_sw", o_io_sw, {14'b0, m_stable});
    chk("changed", {31'b0, o_sw_changed}, {31'b0, m_chg});
    i_sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int k);
    for (int i = 0; i < k; i++) step(raw);
  endtask

  task automatic chk_now(input string tag, input logic [31:0] exp_v);
    #1;
    chk(tag, o_io_sw, exp_v);
  endtask

  // Asynchronous reset between edges; release at a negedge with raw_rel applied.
  task automatic do_reset(input logic [W-1:0] raw_rel);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_io", o_io_sw, 32'h0);
    chk("rst_async_chg", {31'b0, o_sw_changed}, 32'h0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_io", o_io_sw, 32'h0);
    chk("rst_hold_chg", {31'b0, o_sw_changed}, 32'h0);
    i_sw_raw = raw_rel;
    rst_n    = 1'b1;
    n_edge   = 0;
    m_stable = '0;
    m_chg    = 1'b0;
    @(posedge clk);
    model_edge(raw_rel);
  endtask

  initial begin
    logic [W-1:0] r;
    n_vec = 0;
    n_miss = 0;
    n_edge = 0;
    m_stable = '0;
    m_chg = 1'b0;
    rst_n = 1'b0;
    i_sw_raw = 18'h3FFFF;

    // Reset held with all switches high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init_io", o_io_sw, 32'h0);
    chk("rst_init_chg", {31'b0, o_sw_changed}, 32'h0);
    @(posedge clk);
    do_reset(18'h0);

    // Clean change to 0x5.
    hold(18'h00005, 12);
    chk_now("clean_final", 32'h5);

    // Bounce reject on bit 0.
    do_reset(18'h0);
    hold(18'h1, 3);
    hold(18'h0, 1);
    hold(18'h1, 3);
    hold(18'h0, 10);
    chk_now("bounce_reject", 32'h0);

    // Bounce then settle on bit 17.
    hold(18'h20000, 1);
    hold(18'h00000, 1);
    hold(18'h20000, 12);
    chk_now("bounce_settle", 32'h20000);

    // Simultaneous then independent drops.
    hold(18'h3FFFF, 10);
    chk_now("all_on", 32'h3FFFF);
    hold(18'h3FFF7, 2);
    hold(18'h3FDF7, 12);
    chk_now("two_drops", 32'h3FDF7);

    // Reset mid-debounce with bit 2 held through reset.
    do_reset(18'h0);
    hold(18'h4, 2);
    do_reset(18'h4);
    hold(18'h4, 4);
    chk_now("mid_rst_early", 32'h0);
    hold(18'h4, 6);
    chk_now("mid_rst_final", 32'h4);

    // Randomized: toggle a few random bits, hold for 1..6 cycles.
    do_reset(18'h0);
    r = '0;
    for (int it = 0; it < 400; it++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      hold(r, int'($urandom_range(1, 6)));
    end
    hold(r, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
